rv_instr_encoder: RTL and testbench



---
 rtl/rv_instr_encoder.sv | 141 ++++++++++++++
 tb/tb_rv_instr_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// RV32I encoder: turns decoded fields into a 32-bit word plus an IMEM word address. Unencodable requests become NOPs.
// Latency: fields accepted at edge N are presented after edge N+1. Throughput is 1 word/cycle.
// Backpressure: a two-stage valid/ready pipeline; in_ready drops only when both stages are full and out_ready is low.
module rv_instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        err_count
);
    typedef struct packed {
        logic [3:0]  kind;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    localparam logic [3:0] K_R = 4'd0, K_IALU = 4'd1, K_LOAD = 4'd2, K_STORE = 4'd3, K_BRANCH = 4'd4,
                           K_LUI = 4'd5, K_AUIPC = 4'd6, K_JAL = 4'd7, K_JALR = 4'd8;
    localparam logic [31:0]       NOP    = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    fields_t            s1_q;
    logic               s1_valid;
    logic               s2_adv;
    logic [31:0]        enc_instr;
    logic               enc_err;
    logic signed [31:0] imm;
    logic               imm12_bad;
    logic [2:0]         f3;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !clear && (!s1_valid || s2_adv);
    assign imm      = s1_q.imm;
    assign f3       = s1_q.funct3;
    assign imm12_bad = (imm < -2048) || (imm > 2047);

    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        case (s1_q.kind)
            K_R: begin
                enc_instr = {1'b0, s1_q.alt, 5'b0, s1_q.rs2, s1_q.rs1, f3, s1_q.rd, 7'b0110011};
                enc_err   = s1_q.alt && (f3 != 3'b000) && (f3 != 3'b101);
            end
            K_IALU: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    enc_instr = {1'b0, s1_q.alt, 5'b0, imm[4:0], s1_q.rs1, f3, s1_q.rd, 7'b0010011};
                    enc_err   = (imm < 0) || (imm > 31) || (s1_q.alt && f3 != 3'b101);
                end else begin
                    enc_instr = {imm[11:0], s1_q.rs1, f3, s1_q.rd, 7'b0010011};
                    enc_err   = imm12_bad || s1_q.alt;
                end
            end
            K_LOAD: begin
                enc_instr = {imm[11:0], s1_q.rs1, f3, s1_q.rd, 7'b0000011};
                enc_err   = imm12_bad || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            K_STORE: begin
                enc_instr = {imm[11:5], s1_q.rs2, s1_q.rs1, f3, imm[4:0], 7'b0100011};
                enc_err   = imm12_bad || (f3 > 3'b010);
            end
            K_BRANCH: begin
                enc_instr = {imm[12], imm[10:5], s1_q.rs2, s1_q.rs1, f3, imm[4:1], imm[11], 7'b1100011};
                enc_err   = (imm < -4096) || (imm > 4094) || imm[0] || (f3 == 3'b010) || (f3 == 3'b011);
            end
            K_LUI, K_AUIPC: begin
                enc_instr = {imm[31:12], s1_q.rd, (s1_q.kind == K_LUI) ? 7'b0110111 : 7'b0010111};
                enc_err   = (imm[11:0] != 12'h000);
            end
            K_JAL: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], s1_q.rd, 7'b1101111};
                enc_err   = (imm < -1048576) || (imm > 1048574) || imm[0];
            end
            K_JALR: begin
                enc_instr = {imm[11:0], s1_q.rs1, f3, s1_q.rd, 7'b1100111};
                enc_err   = imm12_bad || (f3 != 3'b000);
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_instr = NOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            out_addr   <= BASE_A;
            word_count <= '0;
            err_count  <= '0;
        end else if (clear) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= BASE_A;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_addr <= out_addr + 1'b1;
                if (word_count != WC_MAX) word_count <= word_count + 1'b1;
                if (out_err && err_count != 8'hFF) err_count <= err_count + 1'b1;
            end
            // Stage 2 only reloads when the consumer has taken its word, so held outputs stay stable.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= enc_instr;
                    out_err   <= enc_err;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= {in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm};
            end
        end
    end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: default instance for encoding/backpressure, ADDR_W=2/BASE=3 instance for wrap, clear and reset.
module tb_rv_instr_encoder;
    typedef struct {
        logic [3:0]  kind;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    localparam int N = 33;
    vec_t tbl[N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: default parameters
    logic        a_clear = 0, a_in_valid = 0, a_in_ready, a_in_alt = 0, a_out_valid, a_out_ready = 0, a_out_err;
    logic [3:0]  a_in_kind = 0;
    logic [2:0]  a_in_funct3 = 0;
    logic [4:0]  a_in_rd = 0, a_in_rs1 = 0, a_in_rs2 = 0;
    logic [31:0] a_in_imm = 0, a_out_instr;
    logic [9:0]  a_out_addr;
    logic [10:0] a_word_count;
    logic [7:0]  a_err_count;

    // Instance B: ADDR_W=2, BASE=3
    logic        b_clear = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_err;
    logic [31:0] b_out_instr;
    logic [1:0]  b_out_addr;
    logic [2:0]  b_word_count;
    logic [7:0]  b_err_count;

    rv_instr_encoder dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_kind(a_in_kind), .in_funct3(a_in_funct3), .in_alt(a_in_alt), .in_rd(a_in_rd),
        .in_rs1(a_in_rs1), .in_rs2(a_in_rs2), .in_imm(a_in_imm), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_instr(a_out_instr), .out_addr(a_out_addr), .out_err(a_out_err),
        .word_count(a_word_count), .err_count(a_err_count)
    );

    rv_instr_encoder #(.ADDR_W(2), .BASE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_kind(4'd1), .in_funct3(3'd0), .in_alt(1'b0), .in_rd(5'd0),
        .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(32'd0), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_instr(b_out_instr), .out_addr(b_out_addr), .out_err(b_out_err),
        .word_count(b_word_count), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input vec_t v);
        a_in_kind = v.kind; a_in_funct3 = v.f3; a_in_alt = v.alt;
        a_in_rd = v.rd; a_in_rs1 = v.rs1; a_in_rs2 = v.rs2; a_in_imm = v.imm;
        a_in_valid = 1'b1;
    endtask

    // Clear, then stream tbl[first +: n] at full rate and check each word, its address and the counters.
    task automatic run_vecs(input int first, input int n);
        int nerr = 0;
        @(negedge clk); a_clear = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            a_clear = 1'b0;
            if (i >= 2) begin
                chk($sformatf("v%0d_valid", first + i - 2), a_out_valid, 1'b1);
                chk($sformatf("v%0d_instr", first + i - 2), a_out_instr, tbl[first + i - 2].exp);
                chk($sformatf("v%0d_err", first + i - 2), a_out_err, tbl[first + i - 2].err);
                chk($sformatf("v%0d_addr", first + i - 2), a_out_addr, 64'(i - 2));
                if (tbl[first + i - 2].err) nerr++;
            end
            if (i < n) a_drive(tbl[first + i]);
            else a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("run%0d_wc", first), a_word_count, 64'(n));
        chk($sformatf("run%0d_ec", first), a_err_count, 64'(nerr));
        chk($sformatf("run%0d_idle", first), a_out_valid, 1'b0);
    endtask

    initial begin
        // kind, f3, alt, rd, rs1, rs2, imm, expected word, expected err
        tbl[0]  = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0};
        tbl[1]  = '{4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0};
        tbl[2]  = '{4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,          32'h00512423, 1'b0};
        tbl[3]  = '{4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h001000EF, 1'b0};
        tbl[4]  = '{4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3,          32'h00000013, 1'b1};
        tbl[5]  = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000013, 1'b1};
        tbl[6]  = '{4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,         32'h00000013, 1'b1};
        tbl[7]  = '{4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,          32'h40335293, 1'b0};
        tbl[8]  = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0};
        tbl[9]  = '{4'd5, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345000,  32'h12345537, 1'b0};
        tbl[10] = '{4'd2, 3'd2, 1'b0, 5'd4, 5'd3, 5'd0, 32'hFFFFFFFF,   32'hFFF1A203, 1'b0};
        tbl[11] = '{4'd8, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0,          32'h000280E7, 1'b0};
        tbl[12] = '{4'd6, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFF000,   32'hFFFFF117, 1'b0};
        tbl[13] = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   32'h80000093, 1'b0};
        tbl[14] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094,       32'h7E000FE3, 1'b0};
        tbl[15] = '{4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF00000,   32'h8000006F, 1'b0};
        tbl[16] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096,       32'h00000013, 1'b1};
        tbl[17] = '{4'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,          32'h00000013, 1'b1};
        tbl[18] = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001001,   32'h00000013, 1'b1};
        tbl[19] = '{4'd0, 3'd1, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0,          32'h00000013, 1'b1};
        tbl[20] = '{4'd1, 3'd0, 1'b1, 5'd1, 5'd1, 5'd0, 32'd0,          32'h00000013, 1'b1};
        tbl[21] = '{4'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,         32'h00000013, 1'b1};
        tbl[22] = '{4'd3, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0,          32'h00000013, 1'b1};
        tbl[23] = '{4'd8, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,          32'h00000013, 1'b1};
        tbl[24] = '{4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0,          32'h00000013, 1'b1};
        tbl[25] = '{4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFF7FF,   32'h00000013, 1'b1};
        tbl[26] = '{4'd0, 3'd5, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0,          32'h403150B3, 1'b0};
        tbl[27] = '{4'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFFF800,   32'h80510023, 1'b0};
        tbl[28] = '{4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1048574,    32'h7FFFF06F, 1'b0};
        tbl[29] = '{4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1048576,    32'h00000013, 1'b1};
        tbl[30] = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,          32'h00100093, 1'b0};
        tbl[31] = '{4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2,          32'h00200113, 1'b0};
        tbl[32] = '{4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3,          32'h00300193, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_instr", a_out_instr, 32'h0);
        chk("rst_err", a_out_err, 1'b0);
        chk("rst_addr", a_out_addr, 10'd0);
        chk("rst_wc", a_word_count, 11'd0);
        chk("rst_ec", a_err_count, 8'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_b_addr", b_out_addr, 2'd3);

        run_vecs(0, 1);
        run_vecs(1, 2);
        run_vecs(3, 2);
        run_vecs(5, 2);
        run_vecs(7, 23);

        // Backpressure: three inputs against a stalled consumer
        @(negedge clk); a_clear = 1'b1;
        @(negedge clk); a_clear = 1'b0; a_out_ready = 1'b0; a_drive(tbl[30]);
        @(negedge clk); chk("bp_rdy_1", a_in_ready, 1'b1); a_drive(tbl[31]);
        @(negedge clk); chk("bp_rdy_2", a_in_ready, 1'b0); a_drive(tbl[32]);
        @(negedge clk);
        chk("bp_rdy_3", a_in_ready, 1'b0);
        chk("bp_hold_instr", a_out_instr, tbl[30].exp);
        chk("bp_hold_addr", a_out_addr, 10'd0);
        a_out_ready = 1'b1;
        @(negedge clk); a_in_valid = 1'b0;
        chk("bp_w1_instr", a_out_instr, tbl[31].exp);
        chk("bp_w1_addr", a_out_addr, 10'd1);
        @(negedge clk);
        chk("bp_w2_valid", a_out_valid, 1'b1);
        chk("bp_w2_instr", a_out_instr, tbl[32].exp);
        chk("bp_w2_addr", a_out_addr, 10'd2);
        @(negedge clk);
        chk("bp_idle", a_out_valid, 1'b0);
        chk("bp_wc", a_word_count, 11'd3);

        // Small instance: five words wrap the address, word_count saturates at 4
        b_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("b_w%0d_valid", i - 2), b_out_valid, 1'b1);
                chk($sformatf("b_w%0d_instr", i - 2), b_out_instr, 32'h00000013);
                chk($sformatf("b_w%0d_addr", i - 2), b_out_addr, 64'((3 + i - 2) % 4));
            end
            b_in_valid = (i < 5);
        end
        @(negedge clk);
        chk("b_wc_sat", b_word_count, 3'd4);
        chk("b_ec", b_err_count, 8'd0);

        // Clear with S2 holding a word
        b_out_ready = 1'b0; b_in_valid = 1'b1;
        @(negedge clk); b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_s2_full", b_out_valid, 1'b1);
        b_clear = 1'b1;
        @(negedge clk); b_clear = 1'b0;
        chk("b_clr_valid", b_out_valid, 1'b0);
        chk("b_clr_addr", b_out_addr, 2'd3);
        chk("b_clr_wc", b_word_count, 3'd0);
        chk("b_clr_ec", b_err_count, 8'd0);

        // Asynchronous reset mid-stream
        b_out_ready = 1'b1; b_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_pre_rst_wc", b_word_count, 3'd1);
        chk("b_pre_rst_valid", b_out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("b_arst_valid", b_out_valid, 1'b0);
        chk("b_arst_instr", b_out_instr, 32'h0);
        chk("b_arst_addr", b_out_addr, 2'd3);
        chk("b_arst_wc", b_word_count, 3'd0);
        chk("b_arst_ec", b_err_count, 8'd0);
        b_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("b_post_rst_valid", b_out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
